seven_segment_capture: RTL and testbench
========================================

# seven_segment_capture

Passive receiver for the multiplexed four-digit seven-segment bus that the display driver produces. It watches the active-low anode strobes and segment lines and decodes each lit digit back to a hex nibble. It then reassembles the 16-bit value in scan order and publishes it with a one-cycle valid pulse per complete, error-free frame. It sits beside the display driver for on-board loopback and self-check of UART-received data, and it is the reference checker in display-path benches.

## Interface
Parameters:
- SETTLE_CYCLES, 4: cycles after an anode change before segments are sampled; legal range is 2 or more, because the driver's segment lines lag its anodes by one cycle.
- TIMEOUT_CYCLES, 250_000: maximum cycles one digit may stay lit before the block resyncs (2.5 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- seg_i  in  7  segment lines, active-low; bit 6 = a … bit 0 = g.
- anodes_i  in  4  digit strobes, active-low; bit n lights digit n (nibble n).
- data_o  out  16  last committed frame; digit 3 is bits 15:12 and digit 0 is bits 3:0.
- valid_o  out  1  one-cycle pulse when data_o is updated.
- err_o  out  1  one-cycle pulse on a decode, sequence or timeout error.
- locked_o  out  1  high while the block is tracking an error-free scan.

## Operation
- seg_i and anodes_i are registered once (seg_q, anodes_q). An anode change is detected when anodes_q differs from its value on the previous cycle.
- Legal strobe patterns are 1110, 1101, 1011 and 0111 (digit 0..3). Every other pattern is illegal, including 1111.
- The scan order is a rotate-left of the pattern: 1110 → 1101 → 1011 → 0111 → 1110.
- Decode table, seg → nibble (any other pattern is a decode error):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=B
  - 0110001=C, 1000010=D, 0110000=E, 0111000=F
- FSM states:
  - SYNC:
    - Wait for an anode change into 1110.
    - On that change, set idx=0, clear the frame-error flag, and go to SETTLE.
  - SETTLE:
    - Count cycles while anodes_q is stable.
    - At SETTLE_CYCLES, go to CAPTURE.
    - An anode change here sends the block to SYNC with err_o.
  - CAPTURE, one cycle:
    - Decode seg_q into shadow[idx].
    - A decode error sets the frame-error flag.
    - If idx==3, go to COMMIT; otherwise go to HOLD.
  - COMMIT, one cycle:
    - If the frame-error flag is clear: data_o ← shadow, valid_o=1, locked_o=1.
    - If the flag is set: err_o=1, locked_o=0, data_o is unchanged.
    - Then go to HOLD.
  - HOLD:
    - Wait for an anode change.
    - If the new pattern is the expected rotate-left: idx ← idx+1 mod 4, clear the timeout counter, go to SETTLE. On wrap to 0, also clear the frame-error flag.
    - If the new pattern is unexpected or illegal: err_o, locked_o=0, go to SYNC.
- Timeout:
  - A counter runs from each detected anode change and saturates.
  - Reaching TIMEOUT_CYCLES in SETTLE or HOLD gives err_o, locked_o=0 and a return to SYNC.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).

## Timing
- Reset values: data_o=16'h0000, valid_o=0, err_o=0, locked_o=0, FSM=SYNC, idx=0, all counters 0.
- Sampling: the segment sample is the value seg_q holds SETTLE_CYCLES cycles after the cycle in which the anode change is detected. CAPTURE occupies the following cycle.
- Commit latency: valid_o and the new data_o are asserted in the cycle after digit 3's CAPTURE.
- Unchanged frames: valid_o pulses once per frame even when the value is unchanged.
- Error pulses: err_o is at most one pulse per event.
  - A decode error is reported only at COMMIT, once per frame.
  - A sequence or timeout error is reported in the cycle it is detected.
- rst has priority over every event. Asserting rst mid-frame discards shadow and returns all outputs to their reset values on the next edge.
- A frame is committed only after its digit 0 has been entered from SYNC or from HOLD. A partial first frame after lock loss is never committed.

## Configuration
- SEGCAP_DOUBLE_SAMPLE_EN:
  - Defined: CAPTURE becomes two cycles. seg_q is decoded in both cycles, and any mismatch between the two samples counts as a decode error. Latency grows by one cycle per digit.
  - Undefined: a single sample is taken per digit, as described above.

## Test plan
- Bench setup: SETTLE_CYCLES=4, TIMEOUT_CYCLES=64. A behavioural driver runs at 16 cycles per digit, with seg lagging anodes by one cycle.
- Drive 0x1A3F for 3 frames → after reset, first valid_o with data_o=16'h1A3F; locked_o=1; then one valid_o per 64 cycles; err_o never pulses.
- Start the scan mid-frame at 1011 showing 0xBEEF → no commit until a full 1110…0111 sequence; first valid_o carries 16'hBEEF.
- Inject seg=1111111 on digit 2 for one frame of 0x1234 → that frame gives an err_o pulse at COMMIT, locked_o=0, data_o holds 16'h1234 from the prior frame; the next clean frame gives valid_o.
- Skip a digit (1101 → 0111) → err_o in the detection cycle, locked_o=0, SYNC; valid_o resumes after the next full frame.
- Freeze anodes at 1101 → err_o exactly 64 cycles after the last anode change; then assert rst mid-frame → all outputs 0 on the next edge.

Source files
------------

// File: rtl/seven_segment_capture.sv
// Passive decoder for a multiplexed 4-digit active-low seven-segment bus; rebuilds the 16-bit value.
// Build option SEGCAP_DOUBLE_SAMPLE_EN: sample each digit twice and flag any disagreement.
module seven_segment_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  anodes_i,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        locked_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TFIRE = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] SFIRE = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    SYNC     = 3'd0,
    SETTLE   = 3'd1,
    CAPTURE  = 3'd2,
    CAPTURE2 = 3'd3,
    COMMIT   = 3'd4,
    HOLD     = 3'd5
  } state_t;

  // Returns {decode_error, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: seg_decode = {1'b0, 4'h0};
      7'b1001111: seg_decode = {1'b0, 4'h1};
      7'b0010010: seg_decode = {1'b0, 4'h2};
      7'b0000110: seg_decode = {1'b0, 4'h3};
      7'b1001100: seg_decode = {1'b0, 4'h4};
      7'b0100100: seg_decode = {1'b0, 4'h5};
      7'b0100000: seg_decode = {1'b0, 4'h6};
      7'b0001111: seg_decode = {1'b0, 4'h7};
      7'b0000000: seg_decode = {1'b0, 4'h8};
      7'b0000100: seg_decode = {1'b0, 4'h9};
      7'b0001000: seg_decode = {1'b0, 4'hA};
      7'b1100000: seg_decode = {1'b0, 4'hB};
      7'b0110001: seg_decode = {1'b0, 4'hC};
      7'b1000010: seg_decode = {1'b0, 4'hD};
      7'b0110000: seg_decode = {1'b0, 4'hE};
      7'b0111000: seg_decode = {1'b0, 4'hF};
      default:    seg_decode = {1'b1, 4'h0};
    endcase
  endfunction

  state_t       state, state_n;
  logic [6:0]   seg_q;
  logic [3:0]   anodes_q, anodes_prev, exp_pat;
  logic [1:0]   idx, idx_n;
  logic         ferr, ferr_n, ferr_upd;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [15:0]  shadow, shadow_n, shadow_upd, data_n;
  logic         valid_n, err_n, locked_n;
  logic         change, timeout, last_sample, dec_err;
  logic [4:0]   dec;
`ifdef SEGCAP_DOUBLE_SAMPLE_EN
  logic [6:0]   first_seg, first_seg_n;
`endif

  assign change  = (anodes_q != anodes_prev);
  assign timeout = (tcnt >= TFIRE);
  assign dec     = seg_decode(seg_q);

  // Registers: input sampling, FSM state, frame shadow and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= 7'h7F;
      anodes_q    <= 4'hF;
      anodes_prev <= 4'hF;
      state       <= SYNC;
      idx         <= 2'd0;
      ferr        <= 1'b0;
      tcnt        <= '0;
      shadow      <= 16'h0000;
      data_o      <= 16'h0000;
      valid_o     <= 1'b0;
      err_o       <= 1'b0;
      locked_o    <= 1'b0;
`ifdef SEGCAP_DOUBLE_SAMPLE_EN
      first_seg   <= 7'h7F;
`endif
    end else begin
      seg_q       <= seg_i;
      anodes_q    <= anodes_i;
      anodes_prev <= anodes_q;
      state       <= state_n;
      idx         <= idx_n;
      ferr        <= ferr_n;
      tcnt        <= tcnt_n;
      shadow      <= shadow_n;
      data_o      <= data_n;
      valid_o     <= valid_n;
      err_o       <= err_n;
      locked_o    <= locked_n;
`ifdef SEGCAP_DOUBLE_SAMPLE_EN
      first_seg   <= first_seg_n;
`endif
    end
  end

  // Datapath helpers: elapsed-cycle counter, decode error, shadow update, expected next strobe.
  always_comb begin
    if (change) begin
      tcnt_n = TW'(1);
    end else if (tcnt == TMAX) begin
      tcnt_n = tcnt;
    end else begin
      tcnt_n = tcnt + TW'(1);
    end
`ifdef SEGCAP_DOUBLE_SAMPLE_EN
    dec_err = dec[4] | ((state == CAPTURE2) && (seg_q != first_seg));
`else
    dec_err = dec[4];
`endif
    ferr_upd = ferr | dec_err;
    shadow_upd = shadow;
    shadow_upd[{idx, 2'b00} +: 4] = dec[3:0];
    case (idx)
      2'd0:    exp_pat = 4'b1101;
      2'd1:    exp_pat = 4'b1011;
      2'd2:    exp_pat = 4'b0111;
      2'd3:    exp_pat = 4'b1110;
      default: exp_pat = 4'b1111;
    endcase
  end

  // Next-state and output logic; the commit result is registered so it shows in the COMMIT cycle.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    ferr_n      = ferr;
    shadow_n    = shadow;
    data_n      = data_o;
    valid_n     = 1'b0;
    err_n       = 1'b0;
    locked_n    = locked_o;
    last_sample = 1'b0;
`ifdef SEGCAP_DOUBLE_SAMPLE_EN
    first_seg_n = first_seg;
`endif
    case (state)
      SYNC: begin
        if (change && (anodes_q == 4'b1110)) begin
          idx_n   = 2'd0;
          ferr_n  = 1'b0;
          state_n = SETTLE;
        end else begin
          state_n = SYNC;
        end
      end
      SETTLE: begin
        if (change || timeout) begin
          err_n    = 1'b1;
          locked_n = 1'b0;
          state_n  = SYNC;
        end else if (tcnt >= SFIRE) begin
          state_n = CAPTURE;
        end else begin
          state_n = SETTLE;
        end
      end
      CAPTURE: begin
        shadow_n = shadow_upd;
        ferr_n   = ferr_upd;
`ifdef SEGCAP_DOUBLE_SAMPLE_EN
        first_seg_n = seg_q;
        state_n     = CAPTURE2;
`else
        last_sample = 1'b1;
`endif
      end
      CAPTURE2: begin
        shadow_n = shadow_upd;
        ferr_n   = ferr_upd;
`ifdef SEGCAP_DOUBLE_SAMPLE_EN
        last_sample = 1'b1;
`else
        state_n = SYNC;
`endif
      end
      COMMIT: begin
        state_n = HOLD;
      end
      HOLD: begin
        if (change) begin
          if (anodes_q == exp_pat) begin
            idx_n   = idx + 2'd1;
            ferr_n  = (idx == 2'd3) ? 1'b0 : ferr;
            state_n = SETTLE;
          end else begin
            err_n    = 1'b1;
            locked_n = 1'b0;
            state_n  = SYNC;
          end
        end else if (timeout) begin
          err_n    = 1'b1;
          locked_n = 1'b0;
          state_n  = SYNC;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = SYNC;
      end
    endcase

    if (last_sample) begin
      if (idx == 2'd3) begin
        state_n = COMMIT;
        if (!ferr_upd) begin
          data_n   = shadow_upd;
          valid_n  = 1'b1;
          locked_n = 1'b1;
        end else begin
          err_n    = 1'b1;
          locked_n = 1'b0;
        end
      end else begin
        state_n = HOLD;
      end
    end else begin
      valid_n = valid_n;
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench: a behavioural display driver (16 cycles/digit, seg lags anodes by one cycle).
module tb_seven_segment_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_i = 7'h7F;
  logic [3:0]  anodes_i = 4'hF;
  logic [15:0] data_o;
  logic        valid_o, err_o, locked_o;

  int passes = 0;
  int checks = 0;
  int cyc = 0;
  int last_anode_cyc = 0;

  logic        mon_clr = 1'b1;
  int          valid_cnt, err_cnt, bad_gap, last_valid_cyc, last_err_cyc;
  logic [15:0] last_data;

  seven_segment_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .seg_i(seg_i), .anodes_i(anodes_i),
    .data_o(data_o), .valid_o(valid_o), .err_o(err_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_clr) begin
      valid_cnt <= 0; err_cnt <= 0; bad_gap <= 0;
      last_valid_cyc <= 0; last_err_cyc <= 0; last_data <= 16'h0000;
    end else begin
      if (valid_o) begin
        valid_cnt      <= valid_cnt + 1;
        last_data      <= data_o;
        last_valid_cyc <= cyc;
        if (valid_cnt != 0 && (cyc - last_valid_cyc) != 64) bad_gap <= bad_gap + 1;
      end
      if (err_o) begin
        err_cnt      <= err_cnt + 1;
        last_err_cyc <= cyc;
      end
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b0000001;  4'h1: enc = 7'b1001111;
      4'h2: enc = 7'b0010010;  4'h3: enc = 7'b0000110;
      4'h4: enc = 7'b1001100;  4'h5: enc = 7'b0100100;
      4'h6: enc = 7'b0100000;  4'h7: enc = 7'b0001111;
      4'h8: enc = 7'b0000000;  4'h9: enc = 7'b0000100;
      4'hA: enc = 7'b0001000;  4'hB: enc = 7'b1100000;
      4'hC: enc = 7'b0110001;  4'hD: enc = 7'b1000010;
      4'hE: enc = 7'b0110000;  4'hF: enc = 7'b0111000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_digit(input int d, input logic [6:0] seg);
    logic [3:0] one;
    one = 4'b0001;
    @(posedge clk); #1;
    anodes_i = ~(one << d);
    last_anode_cyc = cyc;
    @(posedge clk); #1;
    seg_i = seg;
    repeat (14) @(posedge clk);
  endtask

  task automatic send_frame(input logic [15:0] v, input int bad_digit);
    for (int d = 0; d < 4; d++) begin
      if (d == bad_digit) send_digit(d, 7'b1111111);
      else send_digit(d, enc(v[d*4 +: 4]));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mon_clr = 1'b1; anodes_i = 4'hF; seg_i = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_locked", 32'(locked_o), 32'h0);
    rst = 1'b0; mon_clr = 1'b0;
  endtask

  initial begin
    // Three clean frames of 0x1A3F.
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(16'h1A3F, 9);
    check("t1_valid_cnt", 32'(valid_cnt), 32'd3);
    check("t1_data", 32'(last_data), 32'h1A3F);
    check("t1_locked", 32'(locked_o), 32'd1);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);
    check("t1_gap", 32'(bad_gap), 32'd0);

    // Scan joins mid-frame at digit 2; only the full frame may commit.
    do_reset();
    send_digit(2, enc(4'hE));
    send_digit(3, enc(4'hB));
    check("t2_no_partial", 32'(valid_cnt), 32'd0);
    send_frame(16'hBEEF, 9);
    check("t2_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t2_data", 32'(last_data), 32'hBEEF);
    check("t2_err_cnt", 32'(err_cnt), 32'd0);

    // Bad segment pattern on digit 2: error only at commit, data held.
    do_reset();
    send_frame(16'h1234, 9);
    send_digit(0, enc(4'h4));
    send_digit(1, enc(4'h3));
    send_digit(2, 7'b1111111);
    check("t3_no_early_err", 32'(err_cnt), 32'd0);
    send_digit(3, enc(4'h1));
    check("t3_err_cnt", 32'(err_cnt), 32'd1);
    check("t3_locked", 32'(locked_o), 32'd0);
    check("t3_data_hold", 32'(data_o), 32'h1234);
    check("t3_valid_cnt", 32'(valid_cnt), 32'd1);
    send_frame(16'h5678, 9);
    check("t3_resume_cnt", 32'(valid_cnt), 32'd2);
    check("t3_resume_data", 32'(last_data), 32'h5678);
    check("t3_relocked", 32'(locked_o), 32'd1);

    // Skipped digit: 1101 -> 0111. Register stage + detection gives err_o two edges after the drive.
    do_reset();
    send_frame(16'h1A3F, 9);
    send_digit(0, enc(4'hF));
    send_digit(1, enc(4'h3));
    send_digit(3, enc(4'h1));
    check("t4_err_cnt", 32'(err_cnt), 32'd1);
    check("t4_err_time", 32'(last_err_cyc - last_anode_cyc), 32'd2);
    check("t4_locked", 32'(locked_o), 32'd0);
    send_frame(16'h9C0D, 9);
    check("t4_resume_cnt", 32'(valid_cnt), 32'd2);
    check("t4_resume_data", 32'(last_data), 32'h9C0D);

    // Frozen strobe: err_o 64 cycles after the change is seen (65 edges after the drive).
    do_reset();
    send_frame(16'h1A3F, 9);
    send_digit(0, enc(4'hF));
    send_digit(1, enc(4'h3));
    repeat (80) @(posedge clk);
    #1;
    check("t5_err_cnt", 32'(err_cnt), 32'd1);
    check("t5_err_time", 32'(last_err_cyc - last_anode_cyc), 32'd65);
    check("t5_locked", 32'(locked_o), 32'd0);

    // Relock, then reset in the middle of the next frame.
    send_frame(16'h1A3F, 9);
    send_digit(0, enc(4'hF));
    check("t6_pre_locked", 32'(locked_o), 32'd1);
    check("t6_pre_data", 32'(data_o), 32'h1A3F);
    @(posedge clk); #1;
    anodes_i = 4'b1101;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_data", 32'(data_o), 32'h0);
    check("t6_rst_locked", 32'(locked_o), 32'h0);
    check("t6_rst_valid", 32'(valid_o), 32'h0);
    check("t6_rst_err", 32'(err_o), 32'h0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
